// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x3 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    PRESSED   = 2'd2,
    DEB_REL   = 2'd3
  } state_e;

  localparam int NROWS = 4;
  localparam int NCOLS = 3;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // Physical (row,col) position to key code.
  // Rows 0-2 hold digits 1-9 in reading order; row 3 is "* 0 #".
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-ones so an idle (pulled-up) keypad is seen as "no key".
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NROWS-1:0] row_i,
  output logic [NROWS-1:0] row_o
);

  logic [NROWS-1:0] meta_q;
  logic [NROWS-1:0] sync_q;

  // Two back-to-back flops to resolve metastability on the row lines.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with frame-based press/release debounce.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-strobe a held key
// every REPEAT_FRAMES frames; without it each press strobes exactly once.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_FRAMES  = 50
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NROWS-1:0] row_i,
  output logic [NCOLS-1:0] col_o,
  output logic [3:0]       key_code_o,
  output logic             key_stb_o,
  output logic             key_held_o
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  // Out-of-range parameters leave the scanner running but never accept a key.
  localparam bit CFG_OK = (SCAN_DIV >= 4) && (DEBOUNCE_SCANS >= 2) && (REPEAT_FRAMES >= 1);

  logic [NROWS-1:0] row_sync;

  keypad_row_sync u_row_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .row_i (row_i),
    .row_o (row_sync)
  );

  // ---------------------------------------------------------------------
  // Column scan
  // ---------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_idx_q;
  logic [NCOLS-1:0]  col_q;
  logic              slot_end;
  logic              frame_end;

  assign slot_end  = (slot_q == SLOT_W'(SCAN_DIV - 1));
  assign frame_end = CFG_OK && slot_end && (col_idx_q == 2'd2);

  // Slot counter and one-cold column rotation 110 -> 101 -> 011.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q    <= '0;
      col_idx_q <= 2'd0;
      col_q     <= 3'b110;
    end else if (slot_end) begin
      slot_q    <= '0;
      col_idx_q <= (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      col_q     <= {col_q[1:0], col_q[2]};
    end else begin
      slot_q <= slot_q + 1'b1;
    end
  end

  assign col_o = col_q;

  // ---------------------------------------------------------------------
  // Per-column sampling. Column 2 is never stored: the frame is judged in
  // the same cycle column 2 is sampled, straight from the synchronizer.
  // ---------------------------------------------------------------------
  logic [1:0][NROWS-1:0] frame_q;

  // Capture pressed rows (inverted to active-high) at the end of cols 0/1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_q <= '0;
    end else if (slot_end && (col_idx_q != 2'd2)) begin
      frame_q[col_idx_q[0]] <= ~row_sync;
    end
  end

  logic [NCOLS-1:0][NROWS-1:0] cur;
  logic [3:0]                  nset;
  logic [3:0]                  hit_code;
  logic                        one_key;

  // Classify the 12-bit frame: count pressed keys and remember the code.
  always_comb begin
    cur[0]   = frame_q[0];
    cur[1]   = frame_q[1];
    cur[2]   = ~row_sync;
    nset     = 4'd0;
    hit_code = 4'd0;
    for (int c = 0; c < NCOLS; c++) begin
      for (int r = 0; r < NROWS; r++) begin
        if (cur[c][r]) begin
          nset     = nset + 4'd1;
          hit_code = key_map(2'(r), 2'(c));
        end
      end
    end
  end

  // Multiple keys are deliberately folded into "no key".
  assign one_key = (nset == 4'd1);

  // ---------------------------------------------------------------------
  // Debounce state machine
  // ---------------------------------------------------------------------
  state_e     state_q;
  logic [3:0] cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0] key_code_q;
  logic       key_stb_q;
  logic       key_held_q;
  logic       same_key;

  assign same_key = one_key && (hit_code == key_code_q);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_q;
`endif

  // Press/release debounce; outputs registered, strobe is a one-cycle pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cand_q     <= 4'd0;
      cnt_q      <= '0;
      key_code_q <= 4'd0;
      key_stb_q  <= 1'b0;
      key_held_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q      <= '0;
`endif
    end else begin
      key_stb_q <= 1'b0;
      if (frame_end) begin
        case (state_q)
          IDLE: begin
            if (one_key) begin
              state_q <= DEB_PRESS;
              cand_q  <= hit_code;
              cnt_q   <= CNT_W'(1);
            end
          end
          DEB_PRESS: begin
            if (!one_key) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (hit_code != cand_q) begin
              cand_q <= hit_code;
              cnt_q  <= CNT_W'(1);
            end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              state_q    <= PRESSED;
              key_code_q <= cand_q;
              key_stb_q  <= 1'b1;
              key_held_q <= 1'b1;
              cnt_q      <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_q      <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          PRESSED: begin
            if (same_key) begin
`ifdef KEYPAD_AUTOREPEAT_EN
              if (rep_q == REP_W'(REPEAT_FRAMES - 1)) begin
                rep_q     <= '0;
                key_stb_q <= 1'b1;
              end else begin
                rep_q <= rep_q + 1'b1;
              end
`endif
            end else begin
              state_q <= DEB_REL;
              cnt_q   <= CNT_W'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_q   <= '0;
`endif
            end
          end
          DEB_REL: begin
            if (same_key) begin
              // Bounce on release: back to held, no new strobe.
              state_q <= PRESSED;
              cnt_q   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_q   <= '0;
`endif
            end else if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
              state_q    <= IDLE;
              key_held_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign key_code_o = key_code_q;
  assign key_stb_o  = key_stb_q;
  assign key_held_o = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3, 12-cycle frame).
// Each test resets the DUT so cycle numbers count from reset release:
// frame n is judged in cycle 12n-1 and its strobe is visible in cycle 12n.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row;
  logic [2:0] col;
  logic [3:0] key_code;
  logic       key_stb;
  logic       key_held;

  logic [11:0] keys;   // bit r*3+c = key at (row r, col c) pressed

  int n_vec = 0;
  int n_err = 0;

  int          cyc;
  int          stb_cyc[$];
  logic [3:0]  stb_code[$];
  bit          held_seen;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .REPEAT_FRAMES(5)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .row_i      (row),
    .col_o      (col),
    .key_code_o (key_code),
    .key_stb_o  (key_stb),
    .key_held_o (key_held)
  );

  always #5 clk = ~clk;

  // Passive matrix: a row is pulled low when a pressed key sits on a driven column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && key_stb) begin
      stb_cyc.push_back(cyc);
      stb_code.push_back(key_code);
    end
    if (key_held) held_seen = 1'b1;
  end

  function automatic logic [11:0] kb(input int r, input int c);
    logic [11:0] v;
    v = 12'd0;
    v[r*3+c] = 1'b1;
    return v;
  endfunction

  task automatic run_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    stb_cyc.delete();
    stb_code.delete();
    held_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_reset(input logic [11:0] k);
    @(negedge clk);
    rst  = 1'b1;
    keys = k;
    release_reset();
  endtask

  task automatic test_reset();
    #1;
    n_vec++; if (col !== 3'b110) begin n_err++; $display("FAIL reset_col: got %b expected 110", col); end
    n_vec++; if (key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %h expected 0", key_code); end
    n_vec++; if (key_stb !== 1'b0) begin n_err++; $display("FAIL reset_stb: got %b expected 0", key_stb); end
    n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b expected 0", key_held); end
  endtask

  task automatic test_clean_press();
    do_reset(kb(1, 1));
    run_to(35);
    n_vec++; if (key_stb !== 1'b0 || key_held !== 1'b0) begin n_err++; $display("FAIL k5_early: got stb=%b held=%b expected 0/0", key_stb, key_held); end
    run_to(36);
    n_vec++; if (key_stb !== 1'b1 || key_code !== 4'd5 || key_held !== 1'b1) begin n_err++; $display("FAIL k5_accept: got stb=%b code=%h held=%b expected 1/5/1", key_stb, key_code, key_held); end
    run_to(120);
    keys = 12'd0;
    run_to(155);
    n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL k5_held_rel: got %b expected 1", key_held); end
    run_to(156);
    n_vec++; if (key_held !== 1'b0 || key_code !== 4'd5) begin n_err++; $display("FAIL k5_released: got held=%b code=%h expected 0/5", key_held, key_code); end
    run_to(170);
    n_vec++; if (stb_cyc.size() != 1) begin n_err++; $display("FAIL k5_count: got %0d expected 1", stb_cyc.size()); end
    else if (stb_cyc[0] != 36) begin n_err++; $display("FAIL k5_cycle: got %0d expected 36", stb_cyc[0]); end
  endtask

  task automatic test_bounce();
    do_reset(kb(2, 0));
    run_to(12); keys = 12'd0;
    run_to(24); keys = kb(2, 0);
    run_to(36); keys = 12'd0;
    run_to(48); keys = kb(2, 0);
    run_to(83);
    n_vec++; if (stb_cyc.size() != 0) begin n_err++; $display("FAIL k7_bounce: got %0d strobes expected 0", stb_cyc.size()); end
    run_to(100); keys = 12'd0;
    run_to(150);
    n_vec++; if (stb_cyc.size() != 1) begin n_err++; $display("FAIL k7_count: got %0d expected 1", stb_cyc.size()); end
    else if (stb_cyc[0] != 84 || stb_code[0] !== 4'd7) begin n_err++; $display("FAIL k7_strobe: got cyc=%0d code=%h expected 84/7", stb_cyc[0], stb_code[0]); end
  endtask

  task automatic test_multi();
    logic [2:0] exp_col [4];
    exp_col = '{3'b110, 3'b101, 3'b011, 3'b110};
    do_reset(kb(0, 0) | kb(0, 1));
    for (int i = 0; i < 4; i++) begin
      run_to(4*i + 1);
      n_vec++; if (col !== exp_col[i]) begin n_err++; $display("FAIL multi_col%0d: got %b expected %b", i, col, exp_col[i]); end
    end
    run_to(96);
    n_vec++; if (stb_cyc.size() != 0) begin n_err++; $display("FAIL multi_stb: got %0d strobes expected 0", stb_cyc.size()); end
    n_vec++; if (held_seen !== 1'b0) begin n_err++; $display("FAIL multi_held: got %b expected 0", held_seen); end
  endtask

  task automatic test_back_to_back();
    do_reset(kb(3, 0));
    run_to(48); keys = 12'd0;
    run_to(83);
    n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL star_rel_held: got %b expected 1", key_held); end
    run_to(84); keys = kb(3, 2);
    n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL star_rel_done: got %b expected 0", key_held); end
    run_to(140);
    n_vec++; if (stb_cyc.size() != 2) begin n_err++; $display("FAIL b2b_count: got %0d expected 2", stb_cyc.size()); end
    else begin
      n_vec++; if (stb_cyc[0] != 36 || stb_code[0] !== KEY_STAR) begin n_err++; $display("FAIL b2b_star: got cyc=%0d code=%h expected 36/a", stb_cyc[0], stb_code[0]); end
      n_vec++; if (stb_cyc[1] != 120 || stb_code[1] !== KEY_HASH) begin n_err++; $display("FAIL b2b_hash: got cyc=%0d code=%h expected 120/b", stb_cyc[1], stb_code[1]); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset(kb(2, 2));
    run_to(50);
    n_vec++; if (key_held !== 1'b1 || key_code !== 4'd9) begin n_err++; $display("FAIL k9_pre: got held=%b code=%h expected 1/9", key_held, key_code); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (col !== 3'b110 || key_code !== 4'd0 || key_stb !== 1'b0 || key_held !== 1'b0)
      begin n_err++; $display("FAIL async_reset: got col=%b code=%h stb=%b held=%b expected 110/0/0/0", col, key_code, key_stb, key_held); end
    release_reset();
    run_to(60);
    n_vec++; if (stb_cyc.size() != 1) begin n_err++; $display("FAIL k9_count: got %0d expected 1", stb_cyc.size()); end
    else if (stb_cyc[0] != 36 || stb_code[0] !== 4'd9) begin n_err++; $display("FAIL k9_strobe: got cyc=%0d code=%h expected 36/9", stb_cyc[0], stb_code[0]); end
  endtask

  task automatic test_autorepeat();
    int exp_n;
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_n = 5;
`else
    exp_n = 1;
`endif
    do_reset(kb(3, 1));
    run_to(276); keys = 12'd0;
    run_to(340);
    n_vec++; if (stb_cyc.size() != exp_n) begin n_err++; $display("FAIL rep_count: got %0d expected %0d", stb_cyc.size(), exp_n); end
    else begin
      for (int i = 0; i < exp_n; i++) begin
        n_vec++; if (stb_cyc[i] != 36 + 60*i || stb_code[i] !== 4'd0)
          begin n_err++; $display("FAIL rep_%0d: got cyc=%0d code=%h expected %0d/0", i, stb_cyc[i], stb_code[i], 36 + 60*i); end
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    keys = 12'd0;
    test_reset();
    release_reset();
    test_clean_press();
    test_bounce();
    test_multi();
    test_back_to_back();
    test_mid_reset();
    test_autorepeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x3 matrix keypad (keys 0-9, *, #) and turns it into debounced key events.
- Scans one column at a time, synchronizes the row inputs, and validates a single pressed key over several consecutive scan frames.
- Emits a 4-bit key code with a one-cycle strobe.
- Sits on the input side of the lock controller, feeding its digit-entry logic in place of discrete key lines.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; must be >= 4.
- DEBOUNCE_SCANS, 4: consecutive identical frames needed to accept a press or a release; must be >= 2.
- REPEAT_FRAMES, 50: frames between repeat strobes. Used only with KEYPAD_AUTOREPEAT_EN.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- ROW  input  4  keypad rows, active-low, externally pulled up, asynchronous to CLK.
- COL  output  3  column drive, active-low, exactly one bit low at any time.
- KEY_CODE  output  4  accepted key: 0-9 = digit, 4'hA = *, 4'hB = #.
- KEY_STB  output  1  one-cycle pulse; KEY_CODE is valid in the same cycle.
- KEY_HELD  output  1  high while an accepted key is considered held.

Behaviour:
- Reset values (asynchronous, applied immediately): COL=3'b110, KEY_CODE=0, KEY_STB=0, KEY_HELD=0, state IDLE, all counters 0, synchronizer flops 1.
- Scan:
  - Slot counter runs 0..SCAN_DIV-1.
  - On wrap, COL rotates 110 -> 101 -> 011 -> 110.
  - One frame = 3*SCAN_DIV cycles.
- Sampling:
  - ROW passes through a 2-flop synchronizer.
  - The synchronized rows are sampled in the last cycle of each slot, then inverted (pressed=1) and stored per column.
- Key map by (row,col):
  - r0: 1 2 3
  - r1: 4 5 6
  - r2: 7 8 9
  - r3: * 0 #
- Frame result is evaluated on the cycle the col2 slot ends:
  - NONE: no bits set.
  - KEY(code): exactly one bit set across all 12.
  - MULTI: two or more bits set. MULTI is treated as NONE.
- State machine; cnt counts consecutive matching frames:
  - IDLE:
    - KEY(c) -> DEB_PRESS with cand=c, cnt=1.
  - DEB_PRESS:
    - KEY(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> PRESSED; KEY_CODE<=cand, KEY_STB=1 on the next cycle only, KEY_HELD<=1.
    - KEY(other) -> restart with cand=other, cnt=1.
    - NONE -> IDLE.
  - PRESSED:
    - KEY(KEY_CODE) -> stay.
    - Anything else -> DEB_REL with cnt=1.
  - DEB_REL:
    - Any result other than KEY(KEY_CODE) -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE, KEY_HELD<=0.
    - KEY(KEY_CODE) -> PRESSED, no new strobe.
- Rollover: a second key pressed while the first is held does not strobe. A new key is accepted only after the release debounce completes and a fresh press debounce passes from IDLE.
- Strobe latency: KEY_STB appears 1 cycle after the frame evaluation that completes debounce. With a clean press, that is DEBOUNCE_SCANS frames + 1 cycle after the first frame that saw the key.
- KEY_CODE holds its last accepted value until the next acceptance.
- Reset mid-operation returns to IDLE. A key still held when reset is released is accepted as a new press after DEBOUNCE_SCANS frames.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter counts frames; it is cleared on entry to PRESSED.
  - Each time it reaches REPEAT_FRAMES, KEY_STB pulses again with the same KEY_CODE and the counter clears.
  - Leaving PRESSED (including to DEB_REL) clears it.
  - Returning from DEB_REL to PRESSED restarts the count.
- Undefined: exactly one strobe per accepted press; no repeat counter is present.

Decomposition:
- Package keypad_pkg holds:
  - State enum {IDLE, DEB_PRESS, PRESSED, DEB_REL}.
  - Constants NROWS=4, NCOLS=3, KEY_STAR=4'hA, KEY_HASH=4'hB.
  - Key map function (row,col) -> code.
- One sub-module, keypad_row_sync: a 4-bit 2-flop synchronizer with asynchronous reset to all-ones.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, frame=12 cycles):
- Key 5 (r1,c1) held stable for 10 frames, then released -> single KEY_STB with KEY_CODE=5 after 3 frames; KEY_HELD stays high until 3 frames after release.
- Key 7 bouncing (present/absent on alternate frames for 4 frames), then stable -> no strobe during the bounce; one strobe with code 7 after 3 stable frames.
- Keys 1 and 2 held together for 8 frames -> no KEY_STB; KEY_HELD stays 0; COL keeps rotating 110/101/011.
- Press *, release, press # -> two strobes with codes 4'hA then 4'hB; no strobe during the release debounce.
- RESET pulsed mid-cycle while key 9 is PRESSED and still held -> outputs go to reset values without waiting for a CLK edge; one new strobe with code 9 exactly 3 frames + 1 cycle after the first post-reset frame.
- With KEYPAD_AUTOREPEAT_EN and REPEAT_FRAMES=5, key 0 held for 20 frames after acceptance -> initial strobe plus repeat strobes every 5 frames (4 repeats), all with code 0; without the macro, exactly 1 strobe.
